// File: rtl/dds_pkg.sv
// Shared DDS definitions: accumulator/tuning-word widths and the frequency meter FSM states.
package dds_pkg;
  localparam int unsigned DDS_ACC_W  = 18;
  localparam int unsigned DDS_FREQ_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    HOLD = 2'd2
  } meter_state_e;
endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input followed by a rising-edge detector.
module sync_edge_det #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise_c
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign rise_c = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/dds_freq_meter.sv
// Gated edge counter: counts square_in rising edges over 2^GATE_LOG2 clocks and reports the
// count as a DDS tuning-word estimate with no-signal and overflow flags.
module dds_freq_meter
  import dds_pkg::*;
#(
  parameter int unsigned GATE_LOG2   = DDS_ACC_W,
  parameter int unsigned CNT_W       = DDS_FREQ_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             continuous,
  input  logic             square_in,
  output logic [CNT_W-1:0] freq_est,
  output logic             valid,
  output logic             no_signal,
  output logic             overflow
);

  localparam int unsigned            EDGE_W    = CNT_W + 1;
  localparam logic [EDGE_W-1:0]      EDGE_SAT  = EDGE_W'(1) << CNT_W;
  localparam logic [GATE_LOG2-1:0]   GATE_LAST = '1;
  localparam logic [CNT_W-1:0]       EST_MAX   = '1;

  meter_state_e         state_q, state_d;
  logic [GATE_LOG2-1:0] gate_cnt_q;
  logic [EDGE_W-1:0]    edge_cnt_q;
  logic [EDGE_W-1:0]    edge_cnt_nxt_c;
  logic                 terminal_c;
  logic                 rise_c;

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (square_in),
    .rise_c  (rise_c)
  );

  // Saturating edge count including any rise in the current cycle.
  always_comb begin
    edge_cnt_nxt_c = edge_cnt_q;
    if (rise_c && (edge_cnt_q != EDGE_SAT)) begin
      edge_cnt_nxt_c = edge_cnt_q + EDGE_W'(1);
    end
  end

  assign terminal_c = (state_q == GATE) && enable && (gate_cnt_q == GATE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (enable) state_d = GATE;
      GATE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (terminal_c && !continuous) begin
          state_d = HOLD;
        end
      end
      HOLD: if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters run only in an enabled gate window and restart right after the terminal cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
    end else if ((state_q == GATE) && enable && !terminal_c) begin
      gate_cnt_q <= gate_cnt_q + GATE_LOG2'(1);
      edge_cnt_q <= edge_cnt_nxt_c;
    end else begin
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      freq_est  <= '0;
      valid     <= 1'b0;
      no_signal <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      valid <= terminal_c;
      if (terminal_c) begin
        freq_est  <= edge_cnt_nxt_c[CNT_W] ? EST_MAX : edge_cnt_nxt_c[CNT_W-1:0];
        overflow  <= (edge_cnt_nxt_c == EDGE_SAT);
        no_signal <= (edge_cnt_nxt_c == '0);
      end
    end
  end

endmodule

// File: tb/tb_dds_freq_meter.sv
// Scoreboard bench for dds_freq_meter with a shortened gate window and a behavioural tone source.
module tb_dds_freq_meter;

  localparam int unsigned G    = 10;
  localparam int unsigned CW   = 6;
  localparam int          N    = 1 << G;
  localparam int          MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          continuous = 1'b0;
  logic          square_in = 1'b0;
  logic [CW-1:0] freq_est;
  logic          valid;
  logic          no_signal;
  logic          overflow;

  dds_freq_meter #(
    .GATE_LOG2   (G),
    .CNT_W       (CW),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .continuous (continuous),
    .square_in  (square_in),
    .freq_est   (freq_est),
    .valid      (valid),
    .no_signal  (no_signal),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    est;
    bit    nos;
    bit    ovf;
    longint cyc;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     n_checks = 0;
  int     n_fail = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Tone source: 0 = DDS accumulator MSB, 1 = held low, 2 = toggle every clock.
  int          mode = 1;
  int          tone_f = 0;
  logic [G-1:0] acc = '0;

  always @(negedge clk) begin
    case (mode)
      0: begin
        acc = acc + G'(tone_f);
        square_in = acc[G-1];
      end
      2: square_in = ~square_in;
      default: square_in = 1'b0;
    endcase
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Rising edges in one full window, derived from the tone definition.
  function automatic exp_t model(input int m, input int f, input longint c);
    exp_t e;
    int   rises;
    case (m)
      0:       rises = f;
      2:       rises = N / 2;
      default: rises = 0;
    endcase
    e.est = (rises > MAXV) ? MAXV : rises;
    e.ovf = (rises > MAXV);
    e.nos = (rises == 0);
    e.cyc = c;
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset_n && valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid=1 expected none (cycle %0d, freq_est %0d)",
                 cyc, freq_est);
      end else begin
        mon_e = exp_q.pop_front();
        check("freq_est", longint'(freq_est), longint'(mon_e.est));
        check("no_signal", longint'(no_signal), longint'(mon_e.nos));
        check("overflow", longint'(overflow), longint'(mon_e.ovf));
        check("valid_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL valid_timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic single_shot(input int m, input int f);
    @(negedge clk);
    enable = 1'b0;
    continuous = 1'b0;
    mode = m;
    tone_f = f;
    repeat (8) @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1 exp_q.push_back(model(m, f, cyc + N));
    wait_drain(2 * N);
    repeat (N + 16) @(negedge clk);
    enable = 1'b0;
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1);
  end

  initial begin
    longint c0;
    int     k;
    int     f;

    repeat (3) @(negedge clk);
    check("reset_freq_est", longint'(freq_est), 0);
    check("reset_valid", longint'(valid), 0);
    check("reset_no_signal", longint'(no_signal), 0);
    check("reset_overflow", longint'(overflow), 0);
    reset_n = 1'b1;

    single_shot(0, 1);
    single_shot(0, 2);
    single_shot(0, MAXV);
    single_shot(0, N / 2 - 1);
    single_shot(1, 0);
    single_shot(2, 0);

    repeat (6) begin
      if ($urandom_range(0, 1) == 1) f = int'($urandom_range(1, MAXV));
      else                           f = int'($urandom_range(MAXV + 1, N / 2 - 1));
      single_shot(0, f);
    end

    // Back-to-back windows, then drop enable at the start of the fifth.
    @(negedge clk);
    mode = 0;
    tone_f = 37;
    repeat (8) @(negedge clk);
    continuous = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1 c0 = cyc;
    for (int i = 1; i <= 4; i++) exp_q.push_back(model(0, 37, c0 + longint'(i) * N));
    wait_drain(5 * N);
    enable = 1'b0;
    continuous = 1'b0;
    repeat (N + 16) @(negedge clk);
    check("cont_hold_est", longint'(freq_est), 37);

    // Mid-window abort keeps the previous result.
    tone_f = 20;
    repeat (8) @(negedge clk);
    enable = 1'b1;
    repeat (300) @(negedge clk);
    enable = 1'b0;
    repeat (N + 16) @(negedge clk);
    check("abort_est", longint'(freq_est), 37);
    check("abort_no_signal", longint'(no_signal), 0);
    check("abort_overflow", longint'(overflow), 0);
    single_shot(0, 20);

    // Asynchronous reset mid-window, then restart with enable held high.
    @(negedge clk);
    tone_f = 45;
    repeat (8) @(negedge clk);
    enable = 1'b1;
    repeat (300) @(negedge clk);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("areset_freq_est", longint'(freq_est), 0);
    check("areset_valid", longint'(valid), 0);
    check("areset_no_signal", longint'(no_signal), 0);
    check("areset_overflow", longint'(overflow), 0);
    repeat (3) @(negedge clk);
    k = 0;
    while (!(acc[G-1] == 1'b0 && int'(acc) + 10 * 45 < N / 2) && k < 4 * N) begin
      @(negedge clk);
      k++;
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1 exp_q.push_back(model(0, 45, cyc + N));
    wait_drain(2 * N);
    enable = 1'b0;
    repeat (16) @(negedge clk);

    check("queue_empty", longint'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_freq_meter.md
Name: dds_freq_meter

Overview:
Measures the frequency of a square wave produced by the DDS block and returns it as an estimated 10-bit DDS tuning word. It counts rising edges of the input over a gate window of 2^GATE_LOG2 clocks. With the default window this count equals freq_ctrl exactly. It sits on the receive/monitor side of the DDS: used for loopback self-test and to measure external tones in tuning-word units.

Parameters:
GATE_LOG2, 18, log2 of the gate window length in clk cycles; must equal the DDS phase-accumulator width for a 1:1 tuning-word readout.
CNT_W, 10, width of the edge counter and of freq_est.
SYNC_STAGES, 2, number of synchronizer flops on square_in (minimum 2).

Ports:
clk  input  1  50 MHz system clock.
reset_n  input  1  asynchronous active-low reset.
enable  input  1  high = measure; low = return to IDLE at the next clock.
continuous  input  1  1 = back-to-back windows; 0 = single window per enable rising edge.
square_in  input  1  square wave to measure; may be asynchronous to clk.
freq_est  output  CNT_W  result of the last completed window (edge count, saturated).
valid  output  1  one-cycle pulse when freq_est is updated.
no_signal  output  1  last completed window counted zero edges.
overflow  output  1  last completed window counted more than 2^CNT_W-1 edges.

Behaviour:
- Reset (async, reset_n=0):
  - freq_est=0, valid=0, no_signal=0, overflow=0.
  - Synchronizer flops and edge-detect register = 0.
  - Gate counter = 0, edge counter = 0, FSM = IDLE.
- Input path:
  - square_in passes through SYNC_STAGES flops, then one history flop.
  - rise = sync_out & ~hist.
  - Latency from a square_in edge to rise is SYNC_STAGES+1 clocks.
  - Synchronizer and edge detector run in every state.
- FSM states IDLE, GATE, HOLD:
  - IDLE: counters held at 0. Go to GATE when enable=1 (level).
  - GATE:
    - Gate counter (GATE_LOG2 bits) increments every cycle.
    - Edge counter (CNT_W+1 bits) increments on rise and saturates at 2^CNT_W.
    - When the gate counter equals 2^GATE_LOG2-1 (terminal cycle):
      - A rise in that cycle is included in the count.
      - freq_est <= min(count_next, 2^CNT_W-1), where count_next includes any terminal-cycle rise.
      - overflow <= (count_next == 2^CNT_W); no_signal <= (count_next == 0).
      - valid=1 on the next cycle for one cycle; both counters clear.
    - After the terminal cycle: if continuous=1, stay in GATE (windows are contiguous, no dead cycle); else go to HOLD.
  - HOLD: counters idle. Go to IDLE when enable=0.
  - The next single-shot measurement needs enable to go low and then high again.
- enable=0 in any state: go to IDLE next cycle and clear both counters.
  - The aborted window produces no valid.
  - freq_est and the flags keep their last values.
- Windows are exactly 2^GATE_LOG2 cycles long. A DDS tone at integer word F wraps exactly F times per window, so freq_est=F regardless of window phase, for any 0 < F < 2^(GATE_LOG2-1).
- freq_est, no_signal and overflow change only at window completion (or at reset). They are registered outputs.

Decomposition:
- Shared package (dds_pkg): DDS_ACC_W=18, DDS_FREQ_W=10, and the FSM state enum (IDLE, GATE, HOLD), also usable by the DDS.
- One sub-module: sync_edge_det, covering the SYNC_STAGES synchronizer plus the rise detector, with async active-low reset.
- Everything else stays in dds_freq_meter.

Test Plan:
- Loopback: DDS square_out drives square_in, freq_ctrl=100, continuous=1 → every valid pulse carries freq_est=100, no_signal=0, overflow=0; pulses are spaced exactly 262144 clocks apart.
- Sweep freq_ctrl over 1, 2, 511, 1023 in loopback, single-shot → freq_est equals freq_ctrl each time; one valid per enable rising edge.
- square_in held at 0 for one window → freq_est=0, no_signal=1, valid pulses once.
- square_in toggling every clock (131072 rises per window) → freq_est=1023, overflow=1.
- Drop enable mid-window (cycle 1000) → no valid pulse and freq_est unchanged. Re-raise enable → the next full window reports the correct value.
- Assert reset_n=0 asynchronously mid-window (between clock edges) → all outputs go to 0 immediately. After release with enable=1, the first valid arrives 2^18 clocks (plus 1) after the FSM enters GATE.
